// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
// Imported by the interface, the read-port mux and the top level.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bus of the register file: two read ports,
// two retire lanes and the clear-sweep handshake.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] raddr0;
  logic [DATA_W-1:0] rdata0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic              wr_ready;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output raddr0, raddr1,
    output we0, waddr0, wdata0,
    output we1, waddr1, wdata1,
    output clr_start,
    input  rdata0, rdata1,
    input  wr_ready, clr_busy, clr_done
  );

  modport slave (
    input  raddr0, raddr1,
    input  we0, waddr0, wdata0,
    input  we1, waddr1, wdata1,
    input  clr_start,
    output rdata0, rdata1,
    output wr_ready, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_bypass_mux.sv
// Per-read-port data select: hard-wired zero entry, then same-cycle write
// forwarding (younger lane 1 over lane 0), otherwise the stored array word.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              acc0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              acc1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata
);

  // NOTE: rdata gets a default before any conditional override so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    rdata = arr_data;
    if (BYPASS) begin
      if (acc0 && (waddr0 == raddr)) rdata = wdata0;
      if (acc1 && (waddr1 == raddr)) rdata = wdata1;
    end
    if (ZERO_REG && (raddr == '0)) rdata = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// 2-read / 2-write register file with write-to-read bypass, optional zero
// entry and a one-entry-per-cycle clear sweep used for context flushes.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  logic [DATA_W-1:0] mem [DEPTH];

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;

  logic wr_ready;
  logic acc0, acc1;

  assign wr_ready = (state_q == RF_IDLE);

  // A lane is accepted only when writes are open and it is not aimed at the zero entry.
  assign acc0 = bus.we0 && wr_ready && !(ZERO_REG && (bus.waddr0 == '0));
  assign acc1 = bus.we1 && wr_ready && !(ZERO_REG && (bus.waddr1 == '0));

  // NOTE: the array is built from resettable flops because a reset must
  // leave every entry at zero; a RAM macro could not be cleared this way.
  // NOTE: non-blocking assignments make the later lane-1 write win when both
  // lanes target the same address in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == RF_SWEEP) begin
      mem[ptr_q] <= '0;
    end else begin
      if (acc0) mem[bus.waddr0] <= bus.wdata0;
      if (acc1) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (bus.clr_start) begin
          state_d = RF_SWEEP;
          ptr_d   = '0;
        end
      end
      RF_SWEEP: begin
        // The pointer holds on the last entry instead of wrapping.
        if (ptr_q == PTR_LAST) begin
          state_d = RF_IDLE;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  assign bus.wr_ready = wr_ready;
  assign bus.clr_busy = (state_q == RF_SWEEP);
  assign bus.clr_done = done_q;

  regfile_bypass_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd0 (
    .raddr   (bus.raddr0),
    .arr_data(mem[bus.raddr0]),
    .acc0    (acc0),
    .waddr0  (bus.waddr0),
    .wdata0  (bus.wdata0),
    .acc1    (acc1),
    .waddr1  (bus.waddr1),
    .wdata1  (bus.wdata1),
    .rdata   (bus.rdata0)
  );

  regfile_bypass_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd1 (
    .raddr   (bus.raddr1),
    .arr_data(mem[bus.raddr1]),
    .acc0    (acc0),
    .waddr0  (bus.waddr0),
    .wdata0  (bus.wdata0),
    .acc1    (acc1),
    .waddr1  (bus.waddr1),
    .wdata1  (bus.wdata1),
    .rdata   (bus.rdata1)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected read/status values,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string        name;
    bit           c0;
    logic [DW-1:0] d0;
    bit           c1;
    logic [DW-1:0] d1;
    bit           cs;
    logic         busy;
    logic         ready;
    logic         done;
  } exp_t;

  exp_t    sb_q[$];
  bit      mon_req  = 1'b0;
  int      checks   = 0;
  int      failures = 0;
  logic [DW-1:0] model [32];

  task automatic check(input string name, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s got=%h exp=%h", name, what, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per requested sample, compared at negedge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_req) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow");
      end else begin
        e = sb_q.pop_front();
        if (e.c0) check(e.name, "rdata0", bus.rdata0, e.d0);
        if (e.c1) check(e.name, "rdata1", bus.rdata1, e.d1);
        if (e.cs) begin
          check(e.name, "clr_busy", {31'b0, bus.clr_busy}, {31'b0, e.busy});
          check(e.name, "wr_ready", {31'b0, bus.wr_ready}, {31'b0, e.ready});
          check(e.name, "clr_done", {31'b0, bus.clr_done}, {31'b0, e.done});
        end
      end
    end
  end

  task automatic push_exp(input string n, input bit c0, input logic [DW-1:0] d0,
                          input bit c1, input logic [DW-1:0] d1,
                          input bit cs, input logic busy, input logic ready,
                          input logic done);
    exp_t e;
    e.name = n; e.c0 = c0; e.d0 = d0; e.c1 = c1; e.d1 = d1;
    e.cs = cs; e.busy = busy; e.ready = ready; e.done = done;
    sb_q.push_back(e);
    mon_req = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon_req = 1'b0;
  endtask

  task automatic idle_in();
    bus.we0       = 1'b0;
    bus.we1       = 1'b0;
    bus.clr_start = 1'b0;
  endtask

  task automatic drive_wr(input bit e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input bit e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.we0 = e0; bus.waddr0 = a0; bus.wdata0 = d0;
    bus.we1 = e1; bus.waddr1 = a1; bus.wdata1 = d1;
  endtask

  function automatic logic [DW-1:0] fill_val(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish in time");
  end

  initial begin : stim
    bus.raddr0 = '0; bus.raddr1 = '0;
    drive_wr(1'b0, '0, '0, 1'b0, '0, '0);
    bus.clr_start = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    bus.raddr0 = 5'd3; bus.raddr1 = 5'd31;
    push_exp("reset", 1, 32'h0, 1, 32'h0, 1, 1'b0, 1'b1, 1'b0);
    step();
    rst_n = 1'b1;

    // T1: lane 0 write, bypass then stored read
    drive_wr(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, '0, '0);
    bus.raddr0 = 5'd3; bus.raddr1 = 5'd3;
    push_exp("t1_bypass", 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1, 1'b0, 1'b1, 1'b0);
    step();
    idle_in();
    push_exp("t1_read", 1, 32'hDEAD_BEEF, 0, '0, 0, 1'b0, 1'b0, 1'b0);
    step();

    // T2: both lanes same address, lane 1 wins
    drive_wr(1'b1, 5'd7, 32'h1111, 1'b1, 5'd7, 32'h2222);
    bus.raddr0 = 5'd7; bus.raddr1 = 5'd7;
    push_exp("t2_bypass", 1, 32'h2222, 1, 32'h2222, 0, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    push_exp("t2_read", 1, 32'h2222, 1, 32'h2222, 0, 1'b0, 1'b0, 1'b0);
    step();
    drive_wr(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
    bus.raddr0 = 5'd9; bus.raddr1 = 5'd10;
    push_exp("t2_dual_bypass", 1, 32'h99, 1, 32'hAA, 0, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    push_exp("t2_dual_read", 1, 32'h99, 1, 32'hAA, 0, 1'b0, 1'b0, 1'b0);
    step();

    // T3: bypass on read port 1
    bus.raddr0 = 5'd5; bus.raddr1 = 5'd5;
    push_exp("t3_old", 1, 32'h0, 1, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    step();
    drive_wr(1'b0, '0, '0, 1'b1, 5'd5, 32'hA5A5);
    push_exp("t3_bypass", 1, 32'hA5A5, 1, 32'hA5A5, 0, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    push_exp("t3_stored", 1, 32'hA5A5, 1, 32'hA5A5, 0, 1'b0, 1'b0, 1'b0);
    step();
    drive_wr(1'b1, 5'd11, 32'h1234, 1'b0, '0, '0);
    bus.raddr0 = 5'd11; bus.raddr1 = 5'd11;
    push_exp("t3_lane0_bypass", 1, 32'h1234, 1, 32'h1234, 0, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();

    // T4: zero entry never written, never bypassed
    drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
    bus.raddr0 = 5'd0; bus.raddr1 = 5'd0;
    push_exp("t4_zero_bypass", 1, 32'h0, 1, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    push_exp("t4_zero_read", 1, 32'h0, 1, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    step();

    // T5: fill all entries, sweep, verify cleared
    for (int i = 0; i < 32; i += 2) begin
      drive_wr(1'b1, AW'(i), fill_val(i), 1'b1, AW'(i + 1), fill_val(i + 1));
      model[i]     = (i == 0) ? 32'h0 : fill_val(i);
      model[i + 1] = fill_val(i + 1);
      step();
    end
    idle_in();
    for (int i = 0; i < 32; i += 2) begin
      bus.raddr0 = AW'(i); bus.raddr1 = AW'(i + 1);
      push_exp("t5_fill", 1, model[i], 1, model[i + 1], 0, 1'b0, 1'b0, 1'b0);
      step();
    end
    bus.clr_start = 1'b1;
    drive_wr(1'b1, 5'd4, 32'h4444, 1'b0, '0, '0);
    model[4] = 32'h4444;
    bus.raddr0 = 5'd4; bus.raddr1 = 5'd31;
    push_exp("t5_start", 1, 32'h4444, 1, model[31], 1, 1'b0, 1'b1, 1'b0);
    step();
    idle_in();
    for (int k = 0; k < 32; k++) begin
      bus.raddr0    = AW'(k);
      bus.raddr1    = 5'd31;
      bus.clr_start = (k == 5);
      drive_wr(1'b0, '0, '0, 1'b1, 5'd31, 32'h0BAD);
      push_exp("t5_sweep", 1, model[k], 1, model[31], 1, 1'b1, 1'b0, 1'b0);
      step();
    end
    idle_in();
    bus.raddr0 = 5'd4; bus.raddr1 = 5'd31;
    push_exp("t5_done", 1, 32'h0, 1, 32'h0, 1, 1'b0, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 32; i += 2) begin
      bus.raddr0 = AW'(i); bus.raddr1 = AW'(i + 1);
      push_exp("t5_cleared", 1, 32'h0, 1, 32'h0, 1, 1'b0, 1'b1, 1'b0);
      step();
    end

    // T6: reset in the middle of a sweep
    drive_wr(1'b1, 5'd20, 32'h2020, 1'b1, 5'd25, 32'h2525);
    step();
    idle_in();
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      push_exp("t6_sweep", 0, '0, 0, '0, 1, 1'b1, 1'b0, 1'b0);
      step();
    end
    rst_n = 1'b0;
    bus.raddr0 = 5'd20; bus.raddr1 = 5'd25;
    push_exp("t6_reset", 1, 32'h0, 1, 32'h0, 1, 1'b0, 1'b1, 1'b0);
    step();
    push_exp("t6_reset_hold", 1, 32'h0, 1, 32'h0, 1, 1'b0, 1'b1, 1'b0);
    step();
    rst_n = 1'b1;
    push_exp("t6_no_done", 0, '0, 0, '0, 1, 1'b0, 1'b1, 1'b0);
    step();
    drive_wr(1'b1, 5'd6, 32'h66, 1'b0, '0, '0);
    step();
    idle_in();
    bus.raddr0 = 5'd6; bus.raddr1 = 5'd20;
    push_exp("t6_post_read", 1, 32'h66, 1, 32'h0, 1, 1'b0, 1'b1, 1'b0);
    step();

    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
